// File: rtl/vga_pkg.sv
// VGA raster constants: default 640x480@60 geometry, total/sync derivations, colour codes.
// Pure definitions; no timing or flow control of its own.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int axis_total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    function automatic int sync_start(input int vis, input int front);
        return vis + front;
    endfunction

    function automatic int sync_end(input int vis, input int front, input int sync);
        return vis + front + sync;
    endfunction

    localparam int H_TOTAL  = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int V_TOTAL  = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
    localparam int HS_START = sync_start(DEF_H_VISIBLE, DEF_H_FRONT);
    localparam int HS_END   = sync_end(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC);
    localparam int VS_START = sync_start(DEF_V_VISIBLE, DEF_V_FRONT);
    localparam int VS_END   = sync_end(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC);

    typedef enum logic [2:0] {
        COL_BG      = 3'b000,
        COL_PADDLE2 = 3'b001,
        COL_BORDER  = 3'b010,
        COL_PADDLE1 = 3'b100,
        COL_BALL    = 3'b111
    } colour_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster interface between the timing generator (master) and the object blocks (slave).
// Object bits must be valid one clk after pixel/line change; no backpressure.
interface vga_timing_gen_if;
    logic [9:0] pixel;
    logic [8:0] line;
    logic       PaddleRaster;
    logic       Paddle2Raster;
    logic       BallRaster;

    modport master (output pixel, output line,
                    input PaddleRaster, input Paddle2Raster, input BallRaster);
    modport slave  (input pixel, input line,
                    output PaddleRaster, output Paddle2Raster, output BallRaster);
endinterface

// File: rtl/vga_counter.sv
// Pixel-clock divider plus horizontal/vertical raster counters.
// Counters step on the clk edge where tick is high; free-running, no backpressure.
module vga_counter #(
    parameter int CLK_DIV = 2,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic       clk,
    input  logic       reset,
    output logic       tick,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       frame_wrap
);
    localparam int            DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);

    logic [DW-1:0] div;
    logic          h_wrap;
    logic          v_wrap;

    assign tick       = (div == DIV_LAST);
    assign h_wrap     = (hcnt == H_LAST);
    assign v_wrap     = (vcnt == V_LAST);
    assign frame_wrap = tick && h_wrap && v_wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div  <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                hcnt <= h_wrap ? '0 : hcnt + 10'd1;
                if (h_wrap) begin
                    vcnt <= v_wrap ? '0 : vcnt + 10'd1;
                end
            end
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator and colour composer; VGA_BORDER_EN adds a green frame border.
// HSync/VSync/Rgb trail pixel by one pixel period; free-running, no backpressure.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic                    clk,
    input  logic                    reset,
    vga_timing_gen_if.master        raster,
    output logic                    HSync,
    output logic                    VSync,
    output logic [2:0]              Rgb,
    output logic                    FrameTick
);
    localparam int         H_TOT    = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int         V_TOT    = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam logic [9:0] H_VIS_C  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_C  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_S_C   = 10'(sync_start(H_VISIBLE, H_FRONT));
    localparam logic [9:0] HS_E_C   = 10'(sync_end(H_VISIBLE, H_FRONT, H_SYNC));
    localparam logic [9:0] VS_S_C   = 10'(sync_start(V_VISIBLE, V_FRONT));
    localparam logic [9:0] VS_E_C   = 10'(sync_end(V_VISIBLE, V_FRONT, V_SYNC));

    logic       tick;
    logic       frame_wrap;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       visible;
    logic [2:0] colour;

    vga_counter #(
        .CLK_DIV (CLK_DIV),
        .H_TOTAL (H_TOT),
        .V_TOTAL (V_TOT)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .frame_wrap (frame_wrap)
    );

    // 511 lies outside every object's vertical range, so blanking lines never light an object.
    assign raster.pixel = hcnt;
    assign raster.line  = (vcnt < V_VIS_C) ? vcnt[8:0] : 9'd511;

    assign visible = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);

    always_comb begin
        colour = COL_BG;
`ifdef VGA_BORDER_EN
        if (hcnt == 10'd0 || hcnt == H_VIS_C - 10'd1 ||
            vcnt == 10'd0 || vcnt == V_VIS_C - 10'd1) begin
            colour = COL_BORDER;
        end
`endif
        if (raster.Paddle2Raster) colour = COL_PADDLE2;
        if (raster.PaddleRaster)  colour = COL_PADDLE1;
        if (raster.BallRaster)    colour = COL_BALL;
        if (!visible)             colour = COL_BG;
    end

    // Sync and colour are both computed from the pre-tick counter state so they stay aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HSync     <= 1'b1;
            VSync     <= 1'b1;
            Rgb       <= 3'b000;
            FrameTick <= 1'b0;
        end else begin
            FrameTick <= frame_wrap;
            if (tick) begin
                HSync <= !((hcnt >= HS_S_C) && (hcnt < HS_E_C));
                VSync <= !((vcnt >= VS_S_C) && (vcnt < VS_E_C));
                Rgb   <= colour;
            end
        end
    end
endmodule
